// File: rtl/gf2_poly_reducer.sv
// Bit-serial GF(2)[x] long divider: reduces a 2W-bit carry-less product modulo a monic
// degree-W polynomial, one dividend bit per cycle under a start/done handshake.
module gf2_poly_reducer #(
    parameter int W = 409
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W:0]     divisor,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  r;
    logic [W-1:0]  s;
    logic [W-1:0]  q;
    logic [W-1:0]  d;
    logic [CW-1:0] cnt;

    logic          qbit;
    logic [W-1:0]  r_nxt;
    logic [W-1:0]  q_nxt;

    // The divisor's leading 1 is implied, so only its low W bits are kept; a set
    // qbit cancels the shifted-out x^W term and folds the rest back in.
    always_comb begin
        qbit  = r[W-1];
        r_nxt = {r[W-2:0], s[W-1]} ^ ({W{qbit}} & d);
        q_nxt = {q[W-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            r         <= '0;
            s         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        quotient  <= '0;
                        remainder <= '0;
                        if (divisor[W]) begin
                            r     <= dividend[2*W-1:W];
                            s     <= dividend[W-1:0];
                            d     <= divisor[W-1:0];
                            q     <= '0;
                            cnt   <= '0;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    r   <= r_nxt;
                    s   <= s << 1;
                    q   <= q_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        quotient  <= q_nxt;
                        remainder <= r_nxt;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/gf2_poly_reducer.md
# gf2_poly_reducer

Bit-serial GF(2)[x] polynomial long divider that takes a 2W-bit carry-less product and returns its quotient and remainder modulo a monic degree-W polynomial. It sits directly downstream of the large-integer binary-field multipliers: their 2W-bit output `c` feeds `dividend`, and `remainder` is the reduced GF(2^W) field element. It consumes one dividend bit per cycle under a start/done handshake.

## Interface
- `W`, 409: field width. Remainder width is W, divisor width W+1, dividend width 2W.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous and active-low: asserted when 0, released synchronously to clk by the system.
- `start`  input  1  request pulse; sampled only when accepting (state IDLE or DONE).
- `dividend`  input  2W  polynomial to reduce; bit i is the coefficient of x^i. Captured on the start edge.
- `divisor`  input  W+1  reduction polynomial; bit W must be 1. Captured on the start edge.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse; results are valid in that cycle.
- `err`  output  1  set with `done` when the captured divisor has bit W = 0.
- `quotient`  output  W  quotient coefficients.
- `remainder`  output  W  remainder coefficients (the reduced field element).

## Operation
- Arithmetic is over GF(2): addition is XOR, with no carries anywhere.
- States are IDLE, RUN and DONE.
- IDLE or DONE, `start`=1, captured divisor[W]=1:
  - R ← dividend[2W-1:W]; D ← divisor; S ← dividend[W-1:0]; Q ← 0; counter ← 0.
  - Next state is RUN.
- IDLE or DONE, `start`=1, divisor[W]=0:
  - Next state is DONE with err=1 and quotient=remainder=0.
- RUN, each edge:
  - Form T = {R, S[W-1]} (W+1 bits).
  - qbit = T[W]. If qbit=1 then T ← T ^ D.
  - R ← T[W-1:0]; S ← S << 1; Q ← {Q[W-2:0], qbit}; counter++.
- RUN, on the edge where counter = W-1: perform the final step, copy Q and R to `quotient` and `remainder`, and go to DONE.
- DONE lasts one cycle (`done`=1), then IDLE, unless `start` is sampled in that cycle, which gives a back-to-back restart.
- `start` during RUN is ignored: there is no queueing and the run in progress is unaffected.
- Input changes after the start edge have no effect on the current run.
- `quotient`, `remainder` and `err` hold their last values until the next accepted start. They are cleared to 0 on the start edge.
- Reset at any time, including mid-RUN:
  - State goes to IDLE immediately.
  - All outputs and internal registers go to 0.
  - No `done` is produced for the aborted run.

## Timing
- Reset values: busy=0, done=0, err=0, quotient=0, remainder=0.
- Start sampled at edge t0:
  - busy=1 from after t0 through the cycle ending at edge t0+W.
  - done=1 for exactly the cycle after edge t0+W.
  - Latency is W+1 cycles from the start edge to the cycle carrying done. For W=409, done is visible after edge t0+409.
- Error path: done=1 and err=1 in the cycle after t0; busy stays 0.
- Throughput: one reduction every W+1 cycles when restarting in the DONE cycle.
- `done` and `busy` are never high in the same cycle.
- Combinational depth per step is one (W+1)-bit XOR layer.

## Test plan
- Trinomial remainder:
  - Stimulus: divisor = x^409+x^87+1 (bits 409, 87, 0); dividend = x^409 (bit 409 only).
  - Required: quotient = 1, remainder has only bits 87 and 0 set, err=0, done exactly 410 cycles after the start edge.
- Exact multiple:
  - Stimulus: dividend = divisor·x^5 (bits 414, 92, 5).
  - Required: quotient = 0x20, remainder = 0.
  - Then dividend = 0x5: quotient = 0, remainder = 0x5.
- Bad divisor:
  - Stimulus: divisor = 0 with start.
  - Required: done=1 and err=1 one cycle later; busy never rises; quotient = remainder = 0.
  - Then a valid start: err returns to 0.
- Reset mid-run and ignored start:
  - Stimulus: start, then drive rst=0 asynchronously 200 cycles later.
  - Required: outputs are 0 immediately and no done pulse follows.
  - Separately, start pulses during RUN change nothing.
- Back-to-back and cross-check:
  - Stimulus: restart in each DONE cycle for 1000 random runs, with dividend taken from the 409x409 multiplier product c = a·b.
  - Required: quotient·divisor ^ remainder == dividend every run; remainder matches the software GF(2^409) reference; done spacing is exactly 410 cycles.
